// File: rtl/tilexy_cl_sink.sv
// rtl/tilexy_cl_sink.sv - mesh link sink for wrreq flits: eject FIFO for local lines, pass FIFO toward next hop
module tilexy_cl_sink #(
    parameter int TILE_X     = 0,
    parameter int TILE_Y     = 0,
    parameter int IDX        = 0,
    parameter int DEPTH      = 8,
    parameter int PASS_DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_snd_i,
    input  logic [680:0] in_flit_i,
    output logic         in_stall_o,
    output logic         ej_valid_o,
    input  logic         ej_ready_i,
    output logic [527:0] ej_data_o,
    output logic [36:0]  ej_addr_o,
    output logic [37:0]  ej_size_o,
    output logic         ej_expun_o,
    output logic         out_snd_o,
    output logic [680:0] out_flit_o,
    input  logic         out_hold_i,
    output logic         ovf_err_o
);
    localparam int EAW      = $clog2(DEPTH);
    localparam int PAW      = $clog2(PASS_DEPTH);
    localparam int DONE_BIT = (IDX < 2) ? 592 : 593;

    localparam logic [EAW:0]   EJ_FULL  = (EAW+1)'(DEPTH);
    localparam logic [PAW:0]   PS_FULL  = (PAW+1)'(PASS_DEPTH);
    localparam logic [EAW:0]   EJ_CONE  = (EAW+1)'(1);
    localparam logic [PAW:0]   PS_CONE  = (PAW+1)'(1);
    localparam logic [EAW-1:0] EJ_PONE  = EAW'(1);
    localparam logic [PAW-1:0] PS_PONE  = PAW'(1);

    // Eject entry keeps only what the L2 port consumes: {expun, addr, sz, data[527:0]}
    logic [603:0]   ej_mem [DEPTH];
    logic [680:0]   ps_mem [PASS_DEPTH];

    logic [EAW-1:0] ej_wr_q, ej_wr_d, ej_rd_q, ej_rd_d;
    logic [EAW:0]   ej_cnt_q, ej_cnt_d;
    logic [PAW-1:0] ps_wr_q, ps_wr_d, ps_rd_q, ps_rd_d;
    logic [PAW:0]   ps_cnt_q, ps_cnt_d;
    logic           ovf_q, ovf_d;

    logic match, accept, ej_push, ej_pop, ps_push, ps_pop;
    logic [603:0] ej_head;
    logic [680:0] ps_head;

    assign match = (IDX < 2) ? (in_flit_i[598:594] == 5'(TILE_X))
                             : (in_flit_i[603:599] == 5'(TILE_Y));

    assign in_stall_o = (ej_cnt_q == EJ_FULL) | (ps_cnt_q == PS_FULL);
    assign ej_valid_o = (ej_cnt_q != '0);
    assign out_snd_o  = (ps_cnt_q != '0);
    assign ovf_err_o  = ovf_q;

    assign accept  = in_snd_i & ~in_stall_o;
    assign ej_push = accept & match;
    assign ps_push = accept & ~match;
    assign ej_pop  = ej_valid_o & ej_ready_i;
    assign ps_pop  = out_snd_o & ~out_hold_i;

    assign ej_head    = ej_mem[ej_rd_q];
    assign ej_data_o  = ej_head[527:0];
    assign ej_size_o  = ej_head[565:528];
    assign ej_addr_o  = ej_head[602:566];
    assign ej_expun_o = ej_head[603];

    assign ps_head = ps_mem[ps_rd_q];
    always_comb begin
        out_flit_o           = ps_head;
        out_flit_o[DONE_BIT] = 1'b0;
    end

    always_comb begin
        ej_wr_d  = ej_push ? ej_wr_q + EJ_PONE : ej_wr_q;
        ej_rd_d  = ej_pop  ? ej_rd_q + EJ_PONE : ej_rd_q;
        ps_wr_d  = ps_push ? ps_wr_q + PS_PONE : ps_wr_q;
        ps_rd_d  = ps_pop  ? ps_rd_q + PS_PONE : ps_rd_q;
        ej_cnt_d = ej_cnt_q;
        if (ej_push && !ej_pop)      ej_cnt_d = ej_cnt_q + EJ_CONE;
        else if (!ej_push && ej_pop) ej_cnt_d = ej_cnt_q - EJ_CONE;
        ps_cnt_d = ps_cnt_q;
        if (ps_push && !ps_pop)      ps_cnt_d = ps_cnt_q + PS_CONE;
        else if (!ps_push && ps_pop) ps_cnt_d = ps_cnt_q - PS_CONE;
        // A flit offered against a raised stall is lost; flag it for good
        ovf_d = ovf_q | (in_snd_i & in_stall_o);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ej_wr_q  <= '0;
            ej_rd_q  <= '0;
            ej_cnt_q <= '0;
            ps_wr_q  <= '0;
            ps_rd_q  <= '0;
            ps_cnt_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ej_wr_q  <= ej_wr_d;
            ej_rd_q  <= ej_rd_d;
            ej_cnt_q <= ej_cnt_d;
            ps_wr_q  <= ps_wr_d;
            ps_rd_q  <= ps_rd_d;
            ps_cnt_q <= ps_cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (ej_push) ej_mem[ej_wr_q] <= {in_flit_i[680], in_flit_i[678:642], in_flit_i[641:604], in_flit_i[527:0]};
        if (ps_push) ps_mem[ps_wr_q] <= in_flit_i;
    end
endmodule

// File: tb/tb_tilexy_cl_sink.sv
// tb/tb_tilexy_cl_sink.sv - randomized queue-model bench for tilexy_cl_sink
module tb_tilexy_cl_sink;
    localparam int W = 681;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_snd, ej_ready, out_hold;
    logic [W-1:0] in_flit;
    logic         in_stall, ej_valid, ej_expun, out_snd, ovf_err;
    logic [527:0] ej_data;
    logic [36:0]  ej_addr;
    logic [37:0]  ej_size;
    logic [W-1:0] out_flit;

    tilexy_cl_sink #(.TILE_X(1), .TILE_Y(0), .IDX(0), .DEPTH(8), .PASS_DEPTH(4)) dut (
        .clk_i(clk), .rst_i(rst), .in_snd_i(in_snd), .in_flit_i(in_flit), .in_stall_o(in_stall),
        .ej_valid_o(ej_valid), .ej_ready_i(ej_ready), .ej_data_o(ej_data), .ej_addr_o(ej_addr),
        .ej_size_o(ej_size), .ej_expun_o(ej_expun), .out_snd_o(out_snd), .out_flit_o(out_flit),
        .out_hold_i(out_hold), .ovf_err_o(ovf_err)
    );

    logic [W-1:0] ejq[$];
    logic [W-1:0] psq[$];
    bit           ovf_m;
    int           checks, errors;
    logic [W-1:0] exp_f;

    function automatic logic [W-1:0] rand_flit(input logic [4:0] tx);
        logic [W-1:0] f;
        for (int i = 0; i < W; i++) f[i] = 1'($urandom_range(0, 1));
        f[598:594] = tx;
        f[592]     = 1'b1;
        return f;
    endfunction

    function automatic logic [W-1:0] next_hop_view(input logic [W-1:0] f);
        f[592] = 1'b0;
        return f;
    endfunction

    function automatic bit model_stall();
        return (ejq.size() == 8) || (psq.size() == 4);
    endfunction

    // Drive one cycle of inputs, advance the queue model across the edge, sample 1ns later
    task automatic step(input bit snd, input logic [W-1:0] f, input bit rdy, input bit hold);
        bit stall;
        in_snd = snd; in_flit = f; ej_ready = rdy; out_hold = hold;
        stall = model_stall();
        if (rdy && ejq.size() != 0) void'(ejq.pop_front());
        if (!hold && psq.size() != 0) void'(psq.pop_front());
        if (snd) begin
            if (stall) ovf_m = 1'b1;
            else if (f[598:594] == 5'd1) ejq.push_back(f);
            else psq.push_back(f);
        end
        @(posedge clk); #1;
        in_snd = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_snd = 1'b0; in_flit = '0; ej_ready = 1'b0; out_hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ej_valid !== 1'b0) begin errors++; $display("FAIL reset_ej_valid got %b want 0", ej_valid); end
        checks++; if (out_snd !== 1'b0) begin errors++; $display("FAIL reset_out_snd got %b want 0", out_snd); end
        checks++; if (in_stall !== 1'b0) begin errors++; $display("FAIL reset_in_stall got %b want 0", in_stall); end
        checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf_err got %b want 0", ovf_err); end
        rst = 1'b0;
    endtask

    task automatic test_eject();
        for (int i = 0; i < 4; i++) begin
            step(i < 3, rand_flit(5'd1), 1'b1, 1'b0);
            checks++; if (ej_valid !== (i < 3)) begin errors++; $display("FAIL eject_valid c%0d got %b want %b", i, ej_valid, i < 3); end
            if (ejq.size() != 0) begin
                checks++; if (ej_addr !== ejq[0][678:642]) begin errors++; $display("FAIL eject_addr c%0d got %h want %h", i, ej_addr, ejq[0][678:642]); end
                checks++; if (ej_size !== ejq[0][641:604]) begin errors++; $display("FAIL eject_size c%0d got %h want %h", i, ej_size, ejq[0][641:604]); end
                checks++; if (ej_data !== ejq[0][527:0] || ej_expun !== ejq[0][680]) begin errors++; $display("FAIL eject_data c%0d expun got %b want %b", i, ej_expun, ejq[0][680]); end
            end
        end
    endtask

    task automatic test_pass();
        for (int i = 0; i < 4; i++) begin
            step(i < 2, rand_flit(5'd2), 1'b0, 1'b0);
            checks++; if (out_snd !== (i < 2)) begin errors++; $display("FAIL pass_snd c%0d got %b want %b", i, out_snd, i < 2); end
            checks++; if (ej_valid !== 1'b0) begin errors++; $display("FAIL pass_ej_valid c%0d got %b want 0", i, ej_valid); end
            if (psq.size() != 0) begin
                exp_f = next_hop_view(psq[0]);
                checks++; if (out_flit !== exp_f) begin errors++; $display("FAIL pass_flit c%0d xdone got %b want %b addr got %h want %h", i, out_flit[592], exp_f[592], out_flit[678:642], exp_f[678:642]); end
            end
        end
    endtask

    task automatic test_eject_full();
        for (int i = 0; i < 8; i++) step(1'b1, rand_flit(5'd1), 1'b0, 1'b0);
        checks++; if (in_stall !== 1'b1) begin errors++; $display("FAIL ejfull_stall got %b want 1", in_stall); end
        step(1'b0, '0, 1'b1, 1'b0);
        checks++; if (in_stall !== 1'b0 || ejq.size() != 7) begin errors++; $display("FAIL ejfull_stall_drop got %b want 0", in_stall); end
        for (int i = 0; i < 8; i++) begin
            if (ejq.size() != 0) begin
                checks++; if (ej_valid !== 1'b1 || ej_addr !== ejq[0][678:642]) begin errors++; $display("FAIL ejfull_order c%0d got %h want %h", i, ej_addr, ejq[0][678:642]); end
            end else begin
                checks++; if (ej_valid !== 1'b0) begin errors++; $display("FAIL ejfull_empty got %b want 0", ej_valid); end
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) step(1'b1, rand_flit(5'd2), 1'b0, 1'b1);
        checks++; if (in_stall !== 1'b1) begin errors++; $display("FAIL ovf_stall got %b want 1", in_stall); end
        checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", ovf_err); end
        step(1'b1, rand_flit(5'd2), 1'b0, 1'b1);
        checks++; if (ovf_err !== 1'b1 || ovf_m != 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", ovf_err); end
        exp_f = next_hop_view(psq[0]);
        checks++; if (out_flit !== exp_f) begin errors++; $display("FAIL ovf_hold_head got %h want %h", out_flit[678:642], exp_f[678:642]); end
        for (int i = 0; i < 5; i++) begin
            if (psq.size() != 0) begin
                exp_f = next_hop_view(psq[0]);
                checks++; if (out_snd !== 1'b1 || out_flit !== exp_f) begin errors++; $display("FAIL ovf_drain c%0d got %h want %h", i, out_flit[678:642], exp_f[678:642]); end
            end else begin
                checks++; if (out_snd !== 1'b0) begin errors++; $display("FAIL ovf_drain_empty got %b want 0", out_snd); end
            end
            step(1'b0, '0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_mixed_random();
        bit snd, rdy, hold;
        int sent = 0;
        for (int i = 0; i < 400; i++) begin
            snd  = ($urandom_range(0, 3) != 0) && !model_stall();
            rdy  = 1'($urandom_range(0, 1));
            hold = 1'($urandom_range(0, 1));
            step(snd, rand_flit(sent[0] ? 5'd3 : 5'd1), rdy, hold);
            if (snd) sent++;
            checks++; if (ej_valid !== (ejq.size() != 0) || out_snd !== (psq.size() != 0) || in_stall !== model_stall() || ovf_err !== ovf_m)
                begin errors++; $display("FAIL mix_flags c%0d got v%b s%b st%b o%b want v%b s%b st%b o%b", i, ej_valid, out_snd, in_stall, ovf_err, ejq.size() != 0, psq.size() != 0, model_stall(), ovf_m); end
            if (ejq.size() != 0) begin
                checks++; if (ej_addr !== ejq[0][678:642] || ej_data !== ejq[0][527:0]) begin errors++; $display("FAIL mix_eject c%0d got %h want %h", i, ej_addr, ejq[0][678:642]); end
            end
            if (psq.size() != 0) begin
                exp_f = next_hop_view(psq[0]);
                checks++; if (out_flit !== exp_f) begin errors++; $display("FAIL mix_pass c%0d got %h want %h", i, out_flit[678:642], exp_f[678:642]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) step(1'b1, rand_flit(i < 4 ? 5'd1 : 5'd3), 1'b0, 1'b1);
        checks++; if (ej_valid !== 1'b1 || out_snd !== 1'b1) begin errors++; $display("FAIL rstmid_pre got v%b s%b want 1 1", ej_valid, out_snd); end
        rst = 1'b1; #1;
        checks++; if (ej_valid !== 1'b0 || out_snd !== 1'b0 || in_stall !== 1'b0 || ovf_err !== 1'b0)
            begin errors++; $display("FAIL rstmid_async got v%b s%b st%b o%b want 0 0 0 0", ej_valid, out_snd, in_stall, ovf_err); end
        ejq.delete(); psq.delete(); ovf_m = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0, 1'b1);
            checks++; if (ej_valid !== 1'b0 || out_snd !== 1'b0) begin errors++; $display("FAIL rstmid_stale c%0d got v%b s%b want 0 0", i, ej_valid, out_snd); end
        end
        step(1'b1, rand_flit(5'd1), 1'b0, 1'b0);
        checks++; if (ej_valid !== 1'b1 || ej_addr !== ejq[0][678:642]) begin errors++; $display("FAIL rstmid_fresh got %h want %h", ej_addr, ejq[0][678:642]); end
    endtask

    initial begin
        checks = 0; errors = 0; ovf_m = 1'b0;
        test_reset();
        test_eject();
        test_pass();
        test_eject_full();
        test_overflow();
        test_mixed_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
